// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int P_MEM = 0;
  localparam int P_DBG = 1;
  localparam int CNT_W = 4;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Two-port one-hot grant selection.
// DMEM_ARB_RR_EN defined: round robin on ties; undefined: port 0 has fixed priority.
module dmem_arb_grant
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,  // port favoured on a tie (the one not granted last)
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end
`else
  logic prio_unused;
  assign prio_unused = prio;

  always_comb begin
    gnt = 2'b00;
    if (req[P_MEM])      gnt[P_MEM] = 1'b1;
    else if (req[P_DBG]) gnt[P_DBG] = 1'b1;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (port 0) and the loader/debug master (port 1).
// Tie arbitration is round robin when DMEM_ARB_RR_EN is defined, fixed priority to port 0 otherwise.
//
// state | meaning
// IDLE  | no access; sample req_i and grant
// ISSUE | drive chip enable / write enable with the latched command
// WAIT  | count down read latency, capture read data on terminal count
// DONE  | pulse done for the granted port, then one bubble back to IDLE
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_i,
  input  logic [1:0]    we_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic [1:0]    done_o,
  output logic [DW-1:0] rdata_o,
  output logic          stall_o,
  output logic          busy_o,
  output logic          mem_ce_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             gnt_idx;
  logic             rr_ptr;
  logic [1:0]       gnt;

  dmem_arb_grant u_grant (
    .req  (req_i),
    .prio (rr_ptr),
    .gnt  (gnt)
  );

  assign busy_o  = (state != IDLE);
  assign stall_o = req_i[P_MEM] & ~done_o[P_MEM];

  // The command is held in the mem_* registers for the single ISSUE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt_idx     <= 1'b0;
      rr_ptr      <= 1'b0;
      done_o      <= 2'b00;
      rdata_o     <= '0;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      done_o <= 2'b00;
      case (state)
        IDLE: begin
          if (|gnt) begin
            gnt_idx     <= gnt[P_DBG];
            rr_ptr      <= ~gnt[P_DBG];
            mem_ce_o    <= 1'b1;
            mem_we_o    <= gnt[P_DBG] ? we_i[P_DBG] : we_i[P_MEM];
            mem_addr_o  <= gnt[P_DBG] ? addr1_i : addr0_i;
            mem_wdata_o <= gnt[P_DBG] ? wdata1_i : wdata0_i;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          mem_ce_o    <= 1'b0;
          mem_we_o    <= 1'b0;
          mem_addr_o  <= '0;
          mem_wdata_o <= '0;
          if (mem_we_o) begin
            done_o <= port_onehot(gnt_idx);
            state  <= DONE;
          end else begin
            cnt   <= CNT_W'(RD_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rdata_o <= mem_rdata_i;
            done_o  <= port_onehot(gnt_idx);
            state   <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases plus random traffic against a timeline model.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RD_LAT = 3;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_i = '0, we_i = '0;
  logic [AW-1:0] addr0_i = '0, addr1_i = '0;
  logic [DW-1:0] wdata0_i = '0, wdata1_i = '0, mem_rdata_i = '0;
  logic [1:0]    done_o;
  logic [DW-1:0] rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          stall_o, busy_o, mem_ce_o, mem_we_o;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .done_o(done_o), .rdata_o(rdata_o), .stall_o(stall_o), .busy_o(busy_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Stimulus for the current cycle
  logic [1:0]    drv_req = '0, drv_we = '0;
  logic [AW-1:0] drv_a0 = '0, drv_a1 = '0;
  logic [DW-1:0] drv_w0 = '0, drv_w1 = '0, drv_mrd = '0;

  // Timeline model: one access granted in cycle m_s, finishing at m_s + m_lat
  bit            m_act = 1'b0;
  int            m_s = 0, m_lat = 0;
  bit            m_port = 1'b0, m_we = 1'b0, m_pref = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit exp_ce();
    return m_act && (cyc == m_s + 1);
  endfunction

  function automatic logic [1:0] exp_done();
    if (m_act && (cyc == m_s + m_lat)) return m_port ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  // Compare all outputs against the model, apply this cycle's stimulus, advance the model.
  task automatic tick();
    logic [1:0] ed;
    bit w;
    ed = exp_done();
    chk("done", done_o, ed);
    chk("busy", busy_o, m_act && (cyc > m_s) && (cyc <= m_s + m_lat));
    chk("ce", mem_ce_o, exp_ce());
    chk("we", mem_we_o, exp_ce() && m_we);
    chk("addr", mem_addr_o, exp_ce() ? m_addr : '0);
    chk("wdata", mem_wdata_o, exp_ce() ? m_wdata : '0);
    chk("rdata", rdata_o, m_rdata);
    req_i = drv_req; we_i = drv_we; addr0_i = drv_a0; addr1_i = drv_a1;
    wdata0_i = drv_w0; wdata1_i = drv_w1; mem_rdata_i = drv_mrd;
    #1;
    chk("stall", stall_o, drv_req[0] & ~ed[0]);
    if (m_act && cyc > m_s + m_lat) m_act = 1'b0;
    if (m_act && !m_we && cyc == m_s + 1 + RD_LAT) m_rdata = drv_mrd;
    if (!m_act && drv_req != 2'b00) begin
      if (drv_req == 2'b11) w = RR ? m_pref : 1'b0;
      else w = drv_req[1];
      m_act = 1'b1; m_s = cyc; m_port = w; m_pref = ~w;
      m_we = drv_we[w];
      m_addr = w ? drv_a1 : drv_a0;
      m_wdata = w ? drv_w1 : drv_w0;
      m_lat = m_we ? 2 : 2 + RD_LAT;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic new_cmd(input int p);
    drv_we[p] = 1'($urandom);
    if (p == 0) begin drv_a0 = $urandom; drv_w0 = $urandom; end
    else begin drv_a1 = $urandom; drv_w1 = $urandom; end
  endtask

  initial begin
    bit [1:0] pend;
    logic [1:0] ed;
    bit seen;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ce", mem_ce_o, 1'b0);
    chk("rst_done", done_o, 2'b00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_rdata", rdata_o, '0);
    rst = 1'b1;
    @(negedge clk);

    // Port-0 read; garbage before the capture cycle must not reach rdata_o
    drv_req = 2'b01; drv_we = 2'b00; drv_a0 = 32'h10; drv_mrd = $urandom;
    tick();
    chk("rd0_ce", mem_ce_o, 1'b1);
    chk("rd0_addr", mem_addr_o, 32'h10);
    chk("rd0_stall", stall_o, 1'b1);
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      drv_mrd = (k == RD_LAT + 1) ? 32'hDEADBEEF : $urandom;
      tick();
    end
    chk("rd0_done", done_o, 2'b01);
    chk("rd0_rdata", rdata_o, 32'hDEADBEEF);
    chk("rd0_stall_done", stall_o, 1'b0);
    drv_req = 2'b00;
    tick();

    // Port-1 write
    drv_req = 2'b10; drv_we = 2'b10; drv_a1 = 32'h20; drv_w1 = 32'h12345678;
    tick();
    chk("wr1_we", mem_we_o, 1'b1);
    chk("wr1_addr", mem_addr_o, 32'h20);
    chk("wr1_wdata", mem_wdata_o, 32'h12345678);
    tick();
    chk("wr1_done", done_o, 2'b10);
    chk("wr1_rdata", rdata_o, 32'hDEADBEEF);
    drv_req = 2'b00;
    tick();

    // Tie held for four writes
    drv_req = 2'b11; drv_we = 2'b11; drv_a0 = 32'hA0; drv_a1 = 32'hA1;
    for (int a = 0; a < 4; a++) begin
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        if (done_o != 2'b00) seen = 1'b1;
        else tick();
      end
      chk("tie_seen", seen, 1'b1);
      chk("tie_grant", done_o, (RR && (a % 2 == 1)) ? 2'b10 : 2'b01);
      if (a == 3) drv_req = 2'b00;
      tick();
    end
    tick();

    // Reset asserted during WAIT
    drv_req = 2'b01; drv_we = 2'b00; drv_a0 = 32'h44; drv_mrd = $urandom;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rstw_ce", mem_ce_o, 1'b0);
    chk("rstw_busy", busy_o, 1'b0);
    chk("rstw_done", done_o, 2'b00);
    chk("rstw_rdata", rdata_o, '0);
    chk("rstw_addr", mem_addr_o, '0);
    m_act = 1'b0; m_rdata = '0; m_pref = 1'b0;
    drv_req = 2'b00; req_i = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    cyc++;
    tick();
    drv_req = 2'b01; drv_a0 = 32'h60;
    tick();
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      drv_mrd = (k == RD_LAT + 1) ? 32'hCAFEF00D : $urandom;
      tick();
    end
    chk("rstw_after_done", done_o, 2'b01);
    chk("rstw_after_rdata", rdata_o, 32'hCAFEF00D);
    drv_req = 2'b00;
    tick();

    // Port 0 drops its request after the grant
    drv_req = 2'b01; drv_we = 2'b00; drv_a0 = 32'h50; drv_mrd = $urandom;
    tick();
    drv_req = 2'b00;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      drv_mrd = $urandom;
      tick();
    end
    chk("drop_done", done_o, 2'b01);
    tick();
    chk("drop_idle", busy_o, 1'b0);
    chk("drop_no_done", done_o, 2'b00);
    tick();

    // Random traffic
    pend = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      ed = exp_done();
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 3) == 0) begin pend[p] = 1'b1; new_cmd(p); end
        end else if (ed[p]) begin
          pend[p] = ($urandom_range(0, 1) == 1);
          if (pend[p]) new_cmd(p);
        end else if ($urandom_range(0, 15) == 0) begin
          new_cmd(p);
        end else if ($urandom_range(0, 31) == 0) begin
          pend[p] = 1'b0;
        end
      end
      drv_req = pend;
      drv_mrd = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
